// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: PC_Src encodings, word width and the
// canonical NOP (sll $0,$0,0).
package mips_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      PC_SRC_SEQ = 2'b00,
      PC_SRC_BR  = 2'b01,
      PC_SRC_JR  = 2'b10,
      PC_SRC_J   = 2'b11
   } pc_src_e;

   localparam logic [WORD_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous reset, hold on stall, and squash of the
// wrong-path fetch into a NOP bubble.
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              squash_i,
   input  logic [WORD_W-1:0] inst_i,
   input  logic [WORD_W-1:0] pc_plus4_i,
   output logic [WORD_W-1:0] inst_o,
   output logic [WORD_W-1:0] pc_plus4_o,
   output logic              valid_o
);

   logic [WORD_W-1:0] inst_q, inst_d;
   logic [WORD_W-1:0] pc_plus4_q, pc_plus4_d;
   logic              valid_q, valid_d;

   // A squashed slot still records its PC+4 so the bubble is traceable.
   always_comb begin
      inst_d     = inst_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (!stall_i) begin
         pc_plus4_d = pc_plus4_i;
         if (squash_i) begin
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
         end else begin
            inst_d  = inst_i;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inst_q     <= NOP_WORD;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         inst_q     <= inst_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign inst_o     = inst_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, branch/jump/jr target computation from
// the instruction in ID, next-PC selection and the IF/ID register.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] PC_RESET = 32'h0000_0000,
   parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [1:0]        pc_src,
   input  logic [WORD_W-1:0] jr_target,
   output logic [WORD_W-1:0] imem_addr,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic [WORD_W-1:0] if_id_inst,
   output logic [WORD_W-1:0] if_id_pc_plus4,
   output logic              if_id_valid,
   output logic              flush,
   output logic [WORD_W-1:0] pc
);

   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] pc_plus4;
   logic [WORD_W-1:0] br_off;
   logic [WORD_W-1:0] br_target;
   logic [WORD_W-1:0] j_target;
   logic [WORD_W-1:0] jr_aligned;
   pc_src_e           sel;
   logic              redirect;

   assign sel      = pc_src_e'(pc_src);
   assign pc_plus4 = pc_q + 32'd4;

   // Targets come from the instruction already in ID, not the one being fetched.
   assign br_off     = {{14{if_id_inst[15]}}, if_id_inst[15:0], 2'b00};
   assign br_target  = if_id_pc_plus4 + br_off;
   assign j_target   = {if_id_pc_plus4[31:28], if_id_inst[25:0], 2'b00};
   assign jr_aligned = {jr_target[31:2], 2'b00};

   assign redirect = (sel != PC_SRC_SEQ) && !stall;

   always_comb begin
      pc_d = pc_q;
      if (!stall) begin
         unique case (sel)
            PC_SRC_SEQ: pc_d = pc_plus4;
            PC_SRC_BR:  pc_d = br_target;
            PC_SRC_JR:  pc_d = jr_aligned;
            PC_SRC_J:   pc_d = j_target;
            default:    pc_d = pc_plus4;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

   if_id_reg #(
      .NOP_WORD(NOP_WORD)
   ) u_if_id (
      .clk_i      (clk),
      .rst_i      (rst),
      .stall_i    (stall),
      .squash_i   (redirect),
      .inst_i     (imem_rdata),
      .pc_plus4_i (pc_plus4),
      .inst_o     (if_id_inst),
      .pc_plus4_o (if_id_pc_plus4),
      .valid_o    (if_id_valid)
   );

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign flush     = ~if_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, every cycle
// checked against a behavioural model through an expected-state queue.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic [1:0]  pc_src;
   logic [31:0] jr_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic        flush;
   logic [31:0] pc;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .pc_src         (pc_src),
      .jr_target      (jr_target),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .if_id_inst     (if_id_inst),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .flush          (flush),
      .pc             (pc)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instruction memory: a few fixed words, hashed contents elsewhere
   logic [31:0] mem_ovr [logic [31:0]];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_ovr.exists(a)) return mem_ovr[a];
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   always_comb imem_rdata = mem_word(imem_addr);

   // scoreboard
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // monitor: one expected state per clock edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pc",        pc,                     e.pc);
         chk("imem_addr", imem_addr,              e.pc);
         chk("if_id_inst", if_id_inst,            e.inst);
         chk("if_id_pc4", if_id_pc_plus4,         e.pc4);
         chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
         chk("flush",     {31'b0, flush},         {31'b0, ~e.valid});
      end
   end

   // reference model
   logic [31:0] m_pc    = 32'h0;
   logic [31:0] m_inst  = 32'h0;
   logic [31:0] m_pc4   = 32'h0;
   logic        m_valid = 1'b0;

   task automatic model_step(input logic r, input logic s, input logic [1:0] src,
                             input logic [31:0] jt);
      int          off;
      logic [31:0] tgt;
      logic [31:0] fetched;
      fetched = mem_word(m_pc);
      if (r) begin
         m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!s) begin
         off = int'($signed(m_inst[15:0]));
         case (src)
            2'd1:    tgt = m_pc4 + 32'(off * 4);
            2'd2:    tgt = jt & 32'hFFFF_FFFC;
            2'd3:    tgt = (m_pc4 & 32'hF000_0000) | ({6'b0, m_inst[25:0]} << 2);
            default: tgt = m_pc + 32'd4;
         endcase
         m_pc4 = m_pc + 32'd4;
         if (src != 2'd0) begin
            m_inst = 32'h0; m_valid = 1'b0;
         end else begin
            m_inst = fetched; m_valid = 1'b1;
         end
         m_pc = tgt;
      end
      exp_q.push_back('{pc: m_pc, inst: m_inst, pc4: m_pc4, valid: m_valid});
   endtask

   // driver: one clock per call, returns after the monitor has checked
   task automatic step(input logic r, input logic s, input logic [1:0] src,
                       input logic [31:0] jt);
      @(negedge clk);
      rst = r; stall = s; pc_src = src; jr_target = jt;
      model_step(r, s, src, jt);
      @(posedge clk);
      #2;
   endtask

   task automatic seq(); step(1'b0, 1'b0, 2'd0, 32'h0); endtask

   initial begin
      logic [31:0] held_inst;
      rst = 1'b1; stall = 1'b0; pc_src = 2'd0; jr_target = 32'h0;
      mem_ovr[32'h0000_0000] = 32'h2402_0001;
      mem_ovr[32'h0000_0004] = 32'h1000_FFFF;
      mem_ovr[32'h0000_0008] = 32'h2403_0002;
      mem_ovr[32'h0000_000C] = 32'h1000_0003;
      mem_ovr[32'h2000_0004] = 32'h0800_0040;
      mem_ovr[32'h0000_003C] = 32'h0800_0100;

      // reset and sequential fetch
      step(1'b1, 1'b0, 2'd0, 32'h0);
      step(1'b1, 1'b0, 2'd0, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_flush", {31'b0, flush}, 32'h1);
      seq(); chk("seq_inst_a", if_id_inst, 32'h2402_0001);
      seq(); chk("seq_inst_b", if_id_inst, 32'h1000_FFFF);
      seq(); seq();
      chk("beq_in_id", if_id_pc_plus4, 32'h10);

      // taken forward branch
      step(1'b0, 1'b0, 2'd1, 32'h0);
      chk("br_pc", pc, 32'h1C);
      chk("br_bubble", {31'b0, flush}, 32'h1);
      seq(); chk("br_target_inst", if_id_inst, mem_word(32'h1C));

      // jr, then j from the upper 256MB region
      step(1'b0, 1'b0, 2'd2, 32'h0000_0403);
      chk("jr_pc", pc, 32'h400);
      seq();
      step(1'b0, 1'b0, 2'd2, 32'h2000_0007);
      seq();
      step(1'b0, 1'b0, 2'd3, 32'h0);
      chk("j_pc", pc, 32'h2000_0100);

      // stall at PC 0x40, then stalled jump applied when stall drops
      seq();
      step(1'b0, 1'b0, 2'd2, 32'h0000_003C);
      seq();
      held_inst = if_id_inst;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 2'd0, 32'h0);
         chk("stall_pc", pc, 32'h40);
         chk("stall_inst", if_id_inst, held_inst);
      end
      step(1'b0, 1'b1, 2'd3, 32'h0);
      chk("stall_j_held", pc, 32'h40);
      step(1'b0, 1'b0, 2'd3, 32'h0);
      chk("stall_j_applied", pc, 32'h400);

      // backward branch and PC wrap
      seq();
      step(1'b0, 1'b0, 2'd2, 32'h0000_0004);
      seq();
      step(1'b0, 1'b0, 2'd1, 32'h0);
      chk("back_br_pc", pc, 32'h4);
      seq();
      step(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF);
      chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
      seq();
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_pc4", if_id_pc_plus4, 32'h0);

      // reset during a redirect
      seq();
      step(1'b1, 1'b0, 2'd1, 32'h0);
      chk("rst_redirect_pc", pc, 32'h0);
      chk("rst_redirect_valid", {31'b0, if_id_valid}, 32'h0);
      step(1'b0, 1'b0, 2'd0, 32'h0);

      // random traffic; redirects only while ID holds a real instruction
      for (int i = 0; i < 400; i++) begin
         logic       r, s;
         logic [1:0] src;
         r   = ($urandom_range(0, 99) < 2);
         s   = ($urandom_range(0, 99) < 20);
         src = 2'd0;
         if (m_valid && $urandom_range(0, 99) < 30) src = 2'($urandom_range(1, 3));
         step(r, s, src, $urandom);
      end

      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
